mp_add_seq: RTL

Multi-precision add/subtract sequencer. It reuses one 8-bit Brent-Kung adder instance over several cycles, one byte per clock, least-significant byte first, with the carry held in a register between bytes. Operands come in and the result goes out through a valid/ready handshake. The block sits between a requesting datapath and the shared 8-bit adder core, and it is the only driver of that core.

---
 rtl/mp_add_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer.
// One combinational 8-bit Brent-Kung adder is reused over NBYTES cycles,
// least-significant byte first, with the carry held in carry_r between bytes.
// Optional feature macro: MPADD_SUB_EN (enables the subtract path on input sub).
module mp_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = $clog2(NBYTES);
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry_r;
    logic [KW-1:0]   k_r;

    logic [W-1:0]    b_load_s;
    logic            carry_load_s;
    logic [KW+2:0]   bit_idx_s;
    logic [7:0]      byte_a_s;
    logic [7:0]      byte_b_s;
    logic [7:0]      sum_s;
    logic            carry_out_s;
    logic            carry7_s;
    logic            last_s;
    logic            accept_s;

    // 8-bit Brent-Kung adder: returns {carry_out, sum}. The carry-in is folded
    // into the bit-0 generate so the prefix tree yields every carry directly.
    function automatic logic [8:0] bk_add8(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic       ci);
        logic [7:0] g;
        logic [7:0] p;
        logic [7:0] c;
        logic g0c, g10, g32, p32, g54, p54, g76, p76;
        logic g30, g74, p74, g70, g50, g20, g40, g60;
        g   = a & b;
        p   = a ^ b;
        g0c = g[0] | (p[0] & ci);
        // up-sweep
        g10 = g[1] | (p[1] & g0c);
        g32 = g[3] | (p[3] & g[2]);
        p32 = p[3] & p[2];
        g54 = g[5] | (p[5] & g[4]);
        p54 = p[5] & p[4];
        g76 = g[7] | (p[7] & g[6]);
        p76 = p[7] & p[6];
        g30 = g32 | (p32 & g10);
        g74 = g76 | (p76 & g54);
        p74 = p76 & p54;
        g70 = g74 | (p74 & g30);
        // down-sweep
        g50 = g54 | (p54 & g30);
        g20 = g[2] | (p[2] & g10);
        g40 = g[4] | (p[4] & g30);
        g60 = g[6] | (p[6] & g50);
        c   = {g60, g50, g40, g30, g20, g10, g0c, ci};
        return {g70, p ^ c};
    endfunction

`ifdef MPADD_SUB_EN
    // Operand B / carry seed at accept: subtract is A + ~B + 1, cin ignored.
    always_comb begin
        if (sub) begin
            b_load_s     = ~op_b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = op_b;
            carry_load_s = cin;
        end
    end
`else
    // Add-only build: sub has no function and B is loaded unmodified.
    logic unused_sub_s;
    assign unused_sub_s = sub;
    assign b_load_s     = op_b;
    assign carry_load_s = cin;
`endif

    // Select byte k of both operands and run it through the shared adder.
    always_comb begin
        bit_idx_s              = {k_r, 3'b000};
        byte_a_s               = a_r[bit_idx_s +: 8];
        byte_b_s               = b_r[bit_idx_s +: 8];
        {carry_out_s, sum_s}   = bk_add8(byte_a_s, byte_b_s, carry_r);
        carry7_s               = byte_a_s[7] ^ byte_b_s[7] ^ sum_s[7];
        last_s                 = (k_r == K_LAST);
        accept_s               = (state_r == IDLE) && start_valid;
    end

    // Next-state logic of the IDLE -> RUN -> DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_valid) state_s = RUN;
                else             state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (res_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
        end else begin
            state_r     <= state_s;
            start_ready <= (state_s == IDLE);
            res_valid   <= (state_s == DONE);
        end
    end

    // Operand latch, byte-serial accumulation and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            k_r     <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= op_a;
                        b_r     <= b_load_s;
                        carry_r <= carry_load_s;
                        k_r     <= '0;
                        result  <= '0;
                        cout    <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                RUN: begin
                    result[bit_idx_s +: 8] <= sum_s;
                    carry_r                <= carry_out_s;
                    if (last_s) begin
                        // k saturates on the top byte; the next accept clears it
                        cout <= carry_out_s;
                        ovf  <= carry_out_s ^ carry7_s;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                DONE: begin
                    // result, cout and ovf hold until the next accept
                end
                default: begin
                    carry_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
